multi_event_counter: RTL

//  N-channel event counter. Per channel: counts rising edges of TICK[i], or every cycle

---
 rtl/multi_event_counter_if.sv | 32 +++
 rtl/multi_event_counter.sv | 88 ++++++++
 2 files changed

// File: rtl/multi_event_counter_if.sv
// Control/status bundle for multi_event_counter; channel i lives at bit i / slice [i*W +: W].
interface multi_event_counter_if #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned TARGET_WIDTH = 8
) ();

   localparam int unsigned N = NUM_CHANNELS;
   localparam int unsigned W = TARGET_WIDTH;

   logic [N-1:0]   ENABLE;
   logic [N-1:0]   DOWN;
   logic [N-1:0]   LOAD;
   logic [N-1:0]   CLEAR_STICKY;
   logic [N-1:0]   TICK;
   logic [N*W-1:0] INIT_VAL;
   logic [N*W-1:0] TARGET;
   logic [N*W-1:0] COUNTER;
   logic [N-1:0]   REACHED;
   logic [N-1:0]   REACHED_STICKY;
   logic           ANY_REACHED;

   modport master (
      output ENABLE, DOWN, LOAD, CLEAR_STICKY, TICK, INIT_VAL, TARGET,
      input  COUNTER, REACHED, REACHED_STICKY, ANY_REACHED
   );

   modport slave (
      input  ENABLE, DOWN, LOAD, CLEAR_STICKY, TICK, INIT_VAL, TARGET,
      output COUNTER, REACHED, REACHED_STICKY, ANY_REACHED
   );

endinterface

// File: rtl/multi_event_counter.sv
// N-channel up/down event counter with per-channel target, reach pulse and sticky flag.
module multi_event_counter #(
   parameter int unsigned NUM_CHANNELS     = 4,
   parameter int unsigned TARGET_WIDTH     = 8,
   parameter int unsigned EVENT_IS_CLOCK   = 0,
   parameter int unsigned RESET_IF_REACHED = 1
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   multi_event_counter_if.slave bus
);

   localparam int unsigned N = NUM_CHANNELS;
   localparam int unsigned W = TARGET_WIDTH;
   localparam logic [W-1:0] ONE = W'(1);

   logic [N-1:0][W-1:0] cnt_q;
   logic [N-1:0][W-1:0] cnt_d;
   logic [N-1:0][W-1:0] nxt_v;
   logic [N-1:0][W-1:0] init_v;
   logic [N-1:0][W-1:0] tgt_v;
   logic [N-1:0]        tick_q;
   logic [N-1:0]        ev;
   logic [N-1:0]        step;
   logic [N-1:0]        at_tgt;
   logic [N-1:0]        rch_d;
   logic [N-1:0]        rch_q;
   logic [N-1:0]        stk_d;
   logic [N-1:0]        stk_q;
   logic                any_q;

   assign init_v = bus.INIT_VAL;
   assign tgt_v  = bus.TARGET;

   // Event detect: free-running clock events, or TICK rising edges against last cycle's TICK.
   assign ev   = (EVENT_IS_CLOCK != 0) ? {N{1'b1}} : (bus.TICK & ~tick_q);
   assign step = bus.ENABLE & ev;

   // Next count, reach pulse and sticky flag per channel; LOAD outranks counting.
   always_comb begin
      cnt_d  = cnt_q;
      nxt_v  = cnt_q;
      at_tgt = '0;
      rch_d  = '0;
      for (int i = 0; i < int'(N); i++) begin
         at_tgt[i] = (cnt_q[i] == tgt_v[i]);
         nxt_v[i]  = bus.DOWN[i] ? (cnt_q[i] - ONE) : (cnt_q[i] + ONE);
         if (bus.LOAD[i]) begin
            cnt_d[i] = init_v[i];
         end else if (step[i]) begin
            if (at_tgt[i]) begin
               // Already parked on TARGET: either reload or hold, never re-pulse.
               if (RESET_IF_REACHED != 0) begin
                  cnt_d[i] = init_v[i];
               end
            end else begin
               cnt_d[i] = nxt_v[i];
               rch_d[i] = (nxt_v[i] == tgt_v[i]);
            end
         end
      end
      // A fresh reach beats a simultaneous clear.
      stk_d = rch_d | (stk_q & ~(bus.LOAD | bus.CLEAR_STICKY));
   end

   // State registers; TICK history resets high so a level held through reset is not an edge.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         tick_q <= '1;
         cnt_q  <= '0;
         rch_q  <= '0;
         stk_q  <= '0;
         any_q  <= 1'b0;
      end else begin
         tick_q <= bus.TICK;
         cnt_q  <= cnt_d;
         rch_q  <= rch_d;
         stk_q  <= stk_d;
         any_q  <= |stk_q;
      end
   end

   assign bus.COUNTER        = cnt_q;
   assign bus.REACHED        = rch_q;
   assign bus.REACHED_STICKY = stk_q;
   assign bus.ANY_REACHED    = any_q;

endmodule
